// File: rtl/reg_bank_ctrl.sv
// ============================================================================
// reg_bank_ctrl : valid/ready command sequencer driving a register bank
// Revision 1.0  : initial release
// ============================================================================
`default_nettype none

module reg_bank_ctrl #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic                       cmd_we_i,
  input  logic [ADDR_W-1:0]          cmd_addr_i,
  input  logic [DATA_W-1:0]          cmd_wdata_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [DATA_W-1:0]          rsp_rdata_o,
  output logic                       rsp_err_o,
  output logic [NUM_REGS-1:0]        reg_write_o,
  output logic [NUM_REGS-1:0]        reg_read_o,
  output logic [DATA_W-1:0]          reg_data_o,
  input  logic [NUM_REGS*DATA_W-1:0] reg_value_i
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_WRITE   = 3'd1;
  localparam logic [2:0] c_READ    = 3'd2;
  localparam logic [2:0] c_CAPTURE = 3'd3;
  localparam logic [2:0] c_RESP    = 3'd4;

  localparam logic [ADDR_W:0] c_NUM_REGS = (ADDR_W+1)'(NUM_REGS);

  logic [2:0]          state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [NUM_REGS-1:0] reg_write_q, reg_write_d;
  logic [NUM_REGS-1:0] reg_read_q, reg_read_d;
  logic [DATA_W-1:0]   reg_data_q, reg_data_d;

  logic                w_addr_err;
  logic [NUM_REGS-1:0] w_onehot;
  logic [DATA_W-1:0]   w_bank_or;

  assign w_addr_err = ({1'b0, cmd_addr_i} >= c_NUM_REGS);

  // Non-selected registers drive 0, so an OR across the bank yields the read value
  always_comb begin
    w_onehot  = '0;
    w_bank_or = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_onehot[i] = (cmd_addr_i == ADDR_W'(i));
      w_bank_or   = w_bank_or | reg_value_i[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    reg_write_d = '0;
    reg_read_d  = '0;
    reg_data_d  = reg_data_q;
    case (state_q)
      c_IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          if (w_addr_err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = c_RESP;
          end else if (cmd_we_i) begin
            reg_write_d = w_onehot;
            reg_data_d  = cmd_wdata_i;
            state_d     = c_WRITE;
          end else begin
            reg_read_d  = w_onehot;
            state_d     = c_READ;
          end
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      c_WRITE: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        state_d     = c_RESP;
      end
      c_READ: begin
        state_d = c_CAPTURE;
      end
      c_CAPTURE: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = w_bank_or;
        state_d     = c_RESP;
      end
      c_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          cmd_ready_d = 1'b1;
          state_d     = c_IDLE;
        end
      end
      default: begin
        state_d     = c_IDLE;
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= c_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      reg_write_q <= '0;
      reg_read_q  <= '0;
      reg_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      reg_write_q <= reg_write_d;
      reg_read_q  <= reg_read_d;
      reg_data_q  <= reg_data_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign reg_write_o = reg_write_q;
  assign reg_read_o  = reg_read_q;
  assign reg_data_o  = reg_data_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_bank_ctrl.sv
// ============================================================================
// tb_reg_bank_ctrl : scoreboard bench for reg_bank_ctrl with an attached bank
// Revision 1.0     : initial release
// ============================================================================
`default_nettype none

module tb_reg_bank_ctrl;

  localparam int NUM_REGS = 6;
  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 8;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_t;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic                       cmd_valid = 1'b0;
  logic                       cmd_ready;
  logic                       cmd_we = 1'b0;
  logic [ADDR_W-1:0]          cmd_addr = '0;
  logic [DATA_W-1:0]          cmd_wdata = '0;
  logic                       rsp_valid;
  logic                       rsp_ready = 1'b0;
  logic [DATA_W-1:0]          rsp_rdata;
  logic                       rsp_err;
  logic [NUM_REGS-1:0]        reg_write;
  logic [NUM_REGS-1:0]        reg_read;
  logic [DATA_W-1:0]          reg_data;
  logic [NUM_REGS*DATA_W-1:0] reg_value = '0;

  logic [DATA_W-1:0] bank_mem [NUM_REGS] = '{default: '0};
  logic [DATA_W-1:0] model_mem [NUM_REGS] = '{default: '0};
  rsp_t              exp_q [$];
  rsp_t              mon_e;
  int                total = 0;
  int                bad = 0;
  int                rsp_cnt = 0;

  always #5 clk = ~clk;

  reg_bank_ctrl #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .reg_write_o(reg_write), .reg_read_o(reg_read), .reg_data_o(reg_data),
    .reg_value_i(reg_value)
  );

  // Attached bank: unread registers present 0, read value registers on the strobe edge
  always @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_write[i]) bank_mem[i] <= reg_data;
      reg_value[i*DATA_W +: DATA_W] <= reg_read[i] ? bank_mem[i] : '0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("strobe_excl", 32'(($countones({reg_write, reg_read}) <= 1)), 1);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
          chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        end
        rsp_cnt++;
      end
    end
  end

  task automatic send(input logic we, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wd, input int hold);
    int                  n;
    int                  lat;
    int                  exp_lat;
    int                  cnt0;
    logic                err;
    logic [NUM_REGS-1:0] exp_w;
    logic [NUM_REGS-1:0] exp_r;
    logic [DATA_W-1:0]   held;
    rsp_t                e;
    err     = (int'(addr) >= NUM_REGS);
    exp_w   = (we && !err)  ? (NUM_REGS'(1) << addr) : '0;
    exp_r   = (!we && !err) ? (NUM_REGS'(1) << addr) : '0;
    exp_lat = err ? 0 : (we ? 1 : 2);
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", 0, 1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wd;
    rsp_ready = (hold == 0);
    e.rdata   = (we || err) ? '0 : model_mem[int'(addr)];
    e.err     = err;
    exp_q.push_back(e);
    if (we && !err) model_mem[int'(addr)] = wd;
    cnt0 = rsp_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_we    = 1'($urandom);
    cmd_addr  = ADDR_W'($urandom);
    cmd_wdata = DATA_W'($urandom);
    chk("accept_wstb", 32'(reg_write), 32'(exp_w));
    chk("accept_rstb", 32'(reg_read), 32'(exp_r));
    if (we && !err) chk("reg_data", 32'(reg_data), 32'(wd));
    lat = 0;
    while (!rsp_valid && lat < 6) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) chk("strobe_clear", 32'({reg_write, reg_read}), 0);
    end
    chk("latency", lat, exp_lat);
    if (rsp_valid) begin
      held = rsp_rdata;
      for (int k = 0; k < hold; k++) begin
        if (k == 1) cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("hold_valid", 32'(rsp_valid), 1);
        chk("hold_rdata", 32'(rsp_rdata), 32'(held));
        chk("hold_cmd_ready", 32'(cmd_ready), 0);
        chk("hold_nostrobe", 32'({reg_write, reg_read}), 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("hs_valid", 32'(rsp_valid), 0);
      chk("hs_cmd_ready", 32'(cmd_ready), 1);
      chk("hs_count", rsp_cnt - cnt0, 1);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #7;
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_strobes", 32'({reg_write, reg_read}), 0);
    chk("rst_reg_data", 32'(reg_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 1);

    send(1'b1, 3'd3, 8'hA5, 0);
    send(1'b0, 3'd3, 8'h00, 0);
    send(1'b0, 3'd7, 8'h00, 0);
    send(1'b1, 3'd6, 8'h5A, 0);
    send(1'b0, 3'd3, 8'h00, 5);
    send(1'b1, 3'd0, 8'h11, 0);
    send(1'b1, 3'd5, 8'h22, 0);
    send(1'b0, 3'd0, 8'h00, 0);
    send(1'b0, 3'd5, 8'h00, 0);

    for (int i = 0; i < 40; i++) begin
      send(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    // Abort a read mid-strobe with reset; no response may follow
    while (!cmd_ready) begin @(posedge clk); #1; end
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 3'd2;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("abort_rstb", 32'(reg_read), 32'(6'b000100));
    #2 rst = 1'b1;
    #1;
    chk("abort_strobes", 32'({reg_write, reg_read}), 0);
    chk("abort_cmd_ready", 32'(cmd_ready), 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_rsp_valid", 32'(rsp_valid), 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_release_ready", 32'(cmd_ready), 1);
    chk("abort_release_valid", 32'(rsp_valid), 0);
    send(1'b0, 3'd0, 8'h00, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
